cond_branch_unit: RTL and testbench
===================================

# cond_branch_unit

Registered condition-resolution and branch-control unit for the pipeline's decode/execute boundary. It holds the architectural NZCV flag register, with same-cycle bypass from the flag-writing stage. It evaluates the 4-bit condition field of each decoded instruction and issues registered branch-taken, link-write and flush controls. A small state machine squashes the configured number of wrong-path slots after every taken branch.

## Interface
Parameters:
- PC_W, 32: width of branch target address.
- FLUSH_CYCLES, 2: cycles flush stays high after a taken branch; legal 0..7; 0 disables flushing.
- CNT_W, 16: width of statistics counters (used only with COND_STATS_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flag_we  in  1  flag write strobe from the flag-setting stage.
- flag_in  in  4  new flags; [3]=N, [2]=Z, [1]=C, [0]=V.
- id_valid  in  1  decode slot holds a real instruction.
- id_cond  in  4  condition field.
- id_b  in  1  instruction is a branch.
- id_l  in  1  branch requests link write.
- id_target  in  PC_W  branch target.
- stall  in  1  decode stalled; no new evaluation.
- cond_true  out  1  registered condition result of last evaluated instruction.
- br_taken  out  1  one-cycle pulse: branch taken.
- link_we  out  1  one-cycle pulse: write return address to link register.
- br_target  out  PC_W  target captured with br_taken.
- flush  out  1  squash younger pipeline slots.
- flags_q  out  4  architectural NZCV.

## Operation
- Effective flags: flag_in when flag_we=1 (bypass), else flags_q. flags_q <= flag_in whenever flag_we=1, in every state, including during stall and flush.
- Condition codes:
  - 0000: Z.
  - 0001: !Z.
  - 0010: C.
  - 0011: !C.
  - 0100: N.
  - 0101: !N.
  - 0110: V.
  - 0111: !V.
  - 1000: C&!Z.
  - 1001: !C|Z.
  - 1010: N==V.
  - 1011: N!=V.
  - 1100: !Z&(N==V).
  - 1101: Z|(N!=V).
  - 1110: always true.
  - 1111: always false.
- Evaluate when id_valid=1, stall=0 and state=IDLE:
  - cond_true <= result.
  - br_taken <= result&id_b.
  - link_we <= result&id_b&id_l.
  - br_target <= id_target when br_taken is set, else hold.
- No evaluation (id_valid=0, or stall=1, or state=FLUSH):
  - br_taken=0 and link_we=0.
  - cond_true holds under stall; it is 0 otherwise.
- FSM has two states:
  - IDLE -> FLUSH when a taken branch is evaluated and FLUSH_CYCLES>0. Counter loads FLUSH_CYCLES-1.
  - FLUSH: flush=1. Counter decrements each cycle. Returns to IDLE in the cycle after the counter reads 0.
  - In FLUSH, decode inputs are ignored. stall does not freeze the counter.
- id_l with id_b=0 has no effect on link_we.

## Timing
- Reset values: cond_true=0, br_taken=0, link_we=0, br_target=0, flush=0, flags_q=0000, state=IDLE, counter=0.
- Latency: one cycle from sampled inputs to all outputs. flush rises in the same cycle as br_taken and stays high exactly FLUSH_CYCLES cycles.
- flag_we and a dependent evaluation in the same cycle: the evaluation uses flag_in.
- A taken branch on the last FLUSH cycle is not possible; the slot is squashed. The first evaluation resumes in the cycle flush drops.
- Reset asserted mid-FLUSH: next cycle state=IDLE and flush=0; pending pulses are dropped.

## Configuration
- COND_STATS_EN defined:
  - Adds outputs taken_cnt and not_taken_cnt, each CNT_W bits.
  - They count evaluated branches (id_b=1) by outcome.
  - They saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - Condition-code localparams (COND_EQ … COND_NV).
  - Flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - The FSM state enum (ST_IDLE, ST_FLUSH).
- One combinational sub-module, cond_eval: inputs flags[3:0] and cond[3:0], output result. It is reused by other execute-stage predication logic.

## Test plan
- Reset then flag_we=1, flag_in=0100, same-cycle id_valid=1, id_cond=0000, id_b=1, id_target=0x100 -> next cycle cond_true=1, br_taken=1, br_target=0x100, flush=1 for 2 cycles, flags_q=0100.
- flags_q=0100, id_cond=0001, id_b=1, id_l=1 -> cond_true=0, br_taken=0, link_we=0, flush stays 0.
- flags_q=1001 (N=1, V=1), id_cond=1100, id_b=1, id_l=1 -> br_taken=1, link_we=1. Then a taken branch presented on both flush cycles -> no br_taken. The same instruction presented in the cycle flush drops -> evaluated, br_taken=1.
- id_cond=1111, id_b=1 under every flag value -> br_taken never asserts. id_cond=1110 -> always taken.
- stall=1 for 3 cycles with a valid taken branch, flag_we=1 pulsing -> no pulses, cond_true held, flags_q updated. Release -> evaluated once.
- Reset asserted during the first flush cycle -> next cycle flush=0, all outputs at reset values. With COND_STATS_EN: 5 taken and 3 not-taken branches -> taken_cnt=5, not_taken_cnt=3.

Source files
------------

// File: rtl/cond_branch_unit_pkg.sv
// cond_branch_unit_pkg: condition codes, NZCV bit indices and FSM states shared by the branch unit
package cond_branch_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// cond_eval: resolves a condition code against NZCV; each odd code is the complement of its even partner
module cond_eval
  import cond_branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       result
);
  logic n, z, c, v, base;
  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];
  always_comb begin
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n == v;
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
  end
  assign result = base ^ cond[0];
endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: NZCV register, condition evaluation, branch/link/flush control; COND_STATS_EN adds branch outcome counters
module cond_branch_unit
  import cond_branch_unit_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flag_we,
  input  logic [3:0]      flag_in,
  input  logic            id_valid,
  input  logic [3:0]      id_cond,
  input  logic            id_b,
  input  logic            id_l,
  input  logic [PC_W-1:0] id_target,
  input  logic            stall,
  output logic            cond_true,
  output logic            br_taken,
  output logic            link_we,
  output logic [PC_W-1:0] br_target,
  output logic            flush,
  output logic [3:0]      flags_q
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
`endif
);
  if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 7 || CNT_W < 1) begin : g_bad_cfg
    $error("cond_branch_unit: FLUSH_CYCLES must be 0..7 and CNT_W >= 1");
  end
  state_t state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [3:0] eff_flags;
  logic result, eval, taken;
  assign eff_flags = flag_we ? flag_in : flags_q;
  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (id_cond),
    .result(result)
  );
  assign eval  = id_valid & ~stall & (state == ST_IDLE);
  assign taken = eval & result & id_b;
  assign flush = state == ST_FLUSH;
  always_comb begin
    state_d = state == ST_IDLE ? ((taken && FLUSH_CYCLES > 0) ? ST_FLUSH : ST_IDLE)
                               : (cnt == 3'd0 ? ST_IDLE : ST_FLUSH);
    cnt_d   = state == ST_IDLE ? ((taken && FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0)
                               : (cnt == 3'd0 ? 3'd0 : cnt - 3'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_true <= 1'b0;
      br_taken  <= 1'b0;
      link_we   <= 1'b0;
      br_target <= '0;
      flags_q   <= 4'b0000;
    end else begin
      flags_q   <= eff_flags;
      cond_true <= eval ? result : (stall ? cond_true : 1'b0);
      br_taken  <= taken;
      link_we   <= taken & id_l;
      if (taken) br_target <= id_target;
    end
  end
`ifdef COND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (eval && id_b) begin
      if (result && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      if (!result && not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: directed vectors checked against a flag/condition model and hand-computed literals
module tb_cond_branch_unit;
  import cond_branch_unit_pkg::*;
  localparam int PC_W = 32;
  localparam int FC = 2;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic reset, flag_we, id_valid, id_b, id_l, stall;
  logic [3:0] flag_in, id_cond, flags_q;
  logic [PC_W-1:0] id_target, br_target;
  logic cond_true, br_taken, link_we, flush;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] taken_cnt, not_taken_cnt;
`endif
  int checks = 0;
  int failures = 0;
  logic check_en = 1'b0;
  always #5 clk = ~clk;
  cond_branch_unit #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_in(flag_in),
    .id_valid(id_valid), .id_cond(id_cond), .id_b(id_b), .id_l(id_l),
    .id_target(id_target), .stall(stall), .cond_true(cond_true),
    .br_taken(br_taken), .link_we(link_we), .br_target(br_target),
    .flush(flush), .flags_q(flags_q)
`ifdef COND_STATS_EN
    , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );
  function automatic logic spec_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return cy;
      COND_CC: return !cy;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return cy && !z;
      COND_LS: return !cy || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  logic [3:0] m_flags;
  logic m_cond, m_bt, m_lw;
  logic [PC_W-1:0] m_tgt;
  int m_squash_left;
  int m_tc, m_nc;
  always @(posedge clk) begin : model
    logic [3:0] ef;
    logic ev, r;
    if (reset) begin
      m_flags <= 4'b0; m_cond <= 1'b0; m_bt <= 1'b0; m_lw <= 1'b0; m_tgt <= '0;
      m_squash_left <= 0; m_tc <= 0; m_nc <= 0;
    end else begin
      ef = flag_we ? flag_in : m_flags;
      ev = id_valid && !stall && m_squash_left == 0;
      r = spec_cond(ef, id_cond);
      m_flags <= ef;
      m_cond <= ev ? r : (stall ? m_cond : 1'b0);
      m_bt <= ev && r && id_b;
      m_lw <= ev && r && id_b && id_l;
      if (ev && r && id_b) m_tgt <= id_target;
      m_squash_left <= (ev && r && id_b) ? FC : (m_squash_left > 0 ? m_squash_left - 1 : 0);
      if (ev && id_b && r && m_tc < 2**CNT_W - 1) m_tc <= m_tc + 1;
      if (ev && id_b && !r && m_nc < 2**CNT_W - 1) m_nc <= m_nc + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (check_en) begin
      chk("cond_true", 32'(cond_true), 32'(m_cond));
      chk("br_taken", 32'(br_taken), 32'(m_bt));
      chk("link_we", 32'(link_we), 32'(m_lw));
      chk("br_target", br_target, m_tgt);
      chk("flush", 32'(flush), 32'(m_squash_left > 0));
      chk("flags_q", 32'(flags_q), 32'(m_flags));
`ifdef COND_STATS_EN
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
      chk("not_taken_cnt", 32'(not_taken_cnt), 32'(m_nc));
`endif
    end
  end
  task automatic cyc(input logic v, input logic [3:0] c, input logic b, input logic l,
                     input logic [31:0] t, input logic s, input logic we, input logic [3:0] fi);
    id_valid = v; id_cond = c; id_b = b; id_l = l; id_target = t;
    stall = s; flag_we = we; flag_in = fi;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_cond = 4'h0; id_b = 1'b0; id_l = 1'b0; id_target = '0;
    stall = 1'b0; flag_we = 1'b0; flag_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst cond_true", 32'(cond_true), 0);
    chk("rst flush", 32'(flush), 0);
    chk("rst br_target", br_target, 0);
    chk("rst flags_q", 32'(flags_q), 0);
    check_en = 1'b1;
    reset = 1'b0;
    cyc(1, COND_EQ, 1, 0, 32'h100, 0, 1, 4'b0100);
    chk("t1 cond_true", 32'(cond_true), 1);
    chk("t1 br_taken", 32'(br_taken), 1);
    chk("t1 br_target", br_target, 32'h100);
    chk("t1 flush c1", 32'(flush), 1);
    chk("t1 flags_q", 32'(flags_q), 4'b0100);
    idle(1);
    chk("t1 flush c2", 32'(flush), 1);
    chk("t1 pulse", 32'(br_taken), 0);
    idle(1);
    chk("t1 flush end", 32'(flush), 0);
    cyc(1, COND_NE, 1, 1, 32'h180, 0, 0, 4'h0);
    chk("t2 cond_true", 32'(cond_true), 0);
    chk("t2 br_taken", 32'(br_taken), 0);
    chk("t2 link_we", 32'(link_we), 0);
    chk("t2 flush", 32'(flush), 0);
    cyc(0, COND_EQ, 0, 0, 32'h0, 0, 1, 4'b1001);
    cyc(1, COND_GT, 1, 1, 32'h200, 0, 0, 4'h0);
    chk("t3 br_taken", 32'(br_taken), 1);
    chk("t3 link_we", 32'(link_we), 1);
    cyc(1, COND_AL, 1, 0, 32'h300, 0, 0, 4'h0);
    chk("t3 squash1", 32'(br_taken), 0);
    chk("t3 flush1", 32'(flush), 1);
    cyc(1, COND_AL, 1, 0, 32'h300, 0, 0, 4'h0);
    chk("t3 squash2", 32'(br_taken), 0);
    chk("t3 flush2", 32'(flush), 0);
    chk("t3 target held", br_target, 32'h200);
    cyc(1, COND_AL, 1, 0, 32'h300, 0, 0, 4'h0);
    chk("t3 resume", 32'(br_taken), 1);
    chk("t3 resume tgt", br_target, 32'h300);
    idle(2);
    for (int f = 0; f < 16; f++) begin
      cyc(1, COND_NV, 1, 0, 32'h400 + 32'(f), 0, 1, 4'(f));
      chk("t4 never", 32'(br_taken), 0);
    end
    for (int f = 0; f < 16; f++) begin
      cyc(1, COND_AL, 1, 0, 32'h500 + 32'(f), 0, 1, 4'(f));
      chk("t4 always", 32'(br_taken), 1);
      idle(2);
    end
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        cyc(1, 4'(c), 0, 1, 32'h0, 0, 1, 4'(f));
    cyc(1, COND_HI, 0, 0, 32'h0, 0, 1, 4'b0010);
    chk("pin HI", 32'(cond_true), 1);
    cyc(1, COND_HI, 0, 0, 32'h0, 0, 1, 4'b0110);
    chk("pin HI z", 32'(cond_true), 0);
    cyc(1, COND_LT, 0, 0, 32'h0, 0, 1, 4'b1000);
    chk("pin LT", 32'(cond_true), 1);
    cyc(1, COND_LE, 0, 0, 32'h0, 0, 1, 4'b1001);
    chk("pin LE", 32'(cond_true), 0);
    cyc(1, COND_NE, 0, 0, 32'h0, 0, 1, 4'b0000);
    chk("t5 pre", 32'(cond_true), 1);
    cyc(1, COND_AL, 1, 1, 32'h600, 1, 1, 4'b0100);
    chk("t5 hold1", 32'(cond_true), 1);
    chk("t5 nopulse1", 32'(br_taken), 0);
    chk("t5 flags1", 32'(flags_q), 4'b0100);
    cyc(1, COND_AL, 1, 1, 32'h600, 1, 0, 4'b1111);
    chk("t5 flags2", 32'(flags_q), 4'b0100);
    cyc(1, COND_AL, 1, 1, 32'h600, 1, 1, 4'b1010);
    chk("t5 hold3", 32'(cond_true), 1);
    chk("t5 flags3", 32'(flags_q), 4'b1010);
    chk("t5 nolink", 32'(link_we), 0);
    cyc(1, COND_AL, 1, 1, 32'h600, 0, 0, 4'h0);
    chk("t5 release", 32'(br_taken), 1);
    chk("t5 release lk", 32'(link_we), 1);
    idle(1);
    chk("t5 once", 32'(br_taken), 0);
    idle(1);
    cyc(1, COND_AL, 1, 0, 32'h700, 0, 0, 4'h0);
    chk("t6 flush", 32'(flush), 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6 flush", 32'(flush), 0);
    chk("t6 br_taken", 32'(br_taken), 0);
    chk("t6 cond_true", 32'(cond_true), 0);
    chk("t6 br_target", br_target, 0);
    chk("t6 flags_q", 32'(flags_q), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, COND_AL, 1, 0, 32'h800, 0, 0, 4'h0);
      idle(2);
    end
    for (int i = 0; i < 3; i++) cyc(1, COND_NV, 1, 0, 32'h900, 0, 0, 4'h0);
`ifdef COND_STATS_EN
    chk("stats taken", 32'(taken_cnt), 5);
    chk("stats not_taken", 32'(not_taken_cnt), 3);
`endif
    idle(2);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
